// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg
// Shared constants for the PC/next-PC logic:
//   - jump_op encodings JOP_SEQ, JOP_BR, JOP_J and JOP_JR
//   - default reset PC and the legal instruction-memory window
package fetch_pc_unit_pkg;

   localparam logic [1:0] JOP_SEQ = 2'b00;  // pc + 4
   localparam logic [1:0] JOP_BR  = 2'b01;  // conditional branch
   localparam logic [1:0] JOP_J   = 2'b10;  // j / jal
   localparam logic [1:0] JOP_JR  = 2'b11;  // jr

   localparam logic [31:0] DEF_PC_RESET = 32'h0000_3000;
   localparam logic [31:0] DEF_IM_BASE  = 32'h0000_3000;
   localparam logic [31:0] DEF_IM_LAST  = 32'h0000_6FFC;

endpackage

// File: rtl/fetch_pc_unit_npc_calc.sv
// npc_calc
// Purely combinational next-PC generator and fetch-target legality check.
// Ports:
//   pc           in  32  current fetch address
//   jump_op      in  2   next-PC source select (see package encodings)
//   branch_taken in  1   comparator decision, only used for JOP_BR
//   imm16        in  16  branch offset field
//   imm26        in  26  jump index field
//   rs_data      in  32  jr target
//   npc          out 32  next-PC candidate
//   pc_plus4     out 32  pc + 4
//   legal        out 1   npc is word aligned and inside [IM_BASE, IM_LAST]
module npc_calc
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [31:0] IM_BASE = DEF_IM_BASE,
   parameter logic [31:0] IM_LAST = DEF_IM_LAST
) (
   input  logic [31:0] pc,
   input  logic [1:0]  jump_op,
   input  logic        branch_taken,
   input  logic [15:0] imm16,
   input  logic [25:0] imm26,
   input  logic [31:0] rs_data,
   output logic [31:0] npc,
   output logic [31:0] pc_plus4,
   output logic        legal
);

   logic [31:0] w_br_offset;
   logic [31:0] w_br_target;

   assign pc_plus4    = pc + 32'd4;
   assign w_br_offset = {{14{imm16[15]}}, imm16, 2'b00};
   // Modulo-2^32 add: targets that wrap land outside the window and fail legality.
   assign w_br_target = pc_plus4 + w_br_offset;

   // branch_taken is only consulted inside the JOP_BR arm so an X on it
   // under any other code cannot reach npc.
   always_comb begin
      npc = pc_plus4;
      case (jump_op)
         JOP_SEQ: npc = pc_plus4;
         JOP_BR: begin
            if (branch_taken) npc = w_br_target;
            else              npc = pc_plus4;
         end
         JOP_J:   npc = {pc_plus4[31:28], imm26, 2'b00};
         JOP_JR:  npc = rs_data;
         default: npc = pc_plus4;
      endcase
   end

   assign legal = (npc[1:0] == 2'b00) && (npc >= IM_BASE) && (npc <= IM_LAST);

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
// Program-counter register for the single-cycle MIPS datapath. Registers the
// next PC on every enabled edge, halts on an illegal fetch target and counts
// committed PC updates.
// Ports:
//   clk          in  1   rising-edge clock
//   reset        in  1   synchronous active-high reset
//   en           in  1   PC update enable (0 = stall)
//   jump_op      in  2   next-PC source select
//   branch_taken in  1   comparator decision for conditional branches
//   imm16        in  16  branch offset field
//   imm26        in  26  jump index field
//   rs_data      in  32  jr target
//   pc           out 32  current fetch address (registered)
//   pc_plus4     out 32  pc + 4 (combinational)
//   link_addr    out 32  jal link address, pc + 4
//   npc          out 32  combinational next-PC candidate
//   fault        out 1   sticky illegal-target flag; 1 means HALT
//   fault_addr   out 32  offending target captured at fault
//   commit_cnt   out 32  committed PC updates, wraps silently
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [31:0] PC_RESET = DEF_PC_RESET,
   parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
   parameter logic [31:0] IM_LAST  = DEF_IM_LAST
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [1:0]  jump_op,
   input  logic        branch_taken,
   input  logic [15:0] imm16,
   input  logic [25:0] imm26,
   input  logic [31:0] rs_data,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] link_addr,
   output logic [31:0] npc,
   output logic        fault,
   output logic [31:0] fault_addr,
   output logic [31:0] commit_cnt
);

   logic [31:0] r_pc;
   logic        r_fault;
   logic [31:0] r_fault_addr;
   logic [31:0] r_commit_cnt;
   logic [31:0] w_npc;
   logic [31:0] w_pc_plus4;
   logic        w_legal;

   npc_calc #(
      .IM_BASE (IM_BASE),
      .IM_LAST (IM_LAST)
   ) u_npc_calc (
      .pc           (r_pc),
      .jump_op      (jump_op),
      .branch_taken (branch_taken),
      .imm16        (imm16),
      .imm26        (imm26),
      .rs_data      (rs_data),
      .npc          (w_npc),
      .pc_plus4     (w_pc_plus4),
      .legal        (w_legal)
   );

   // The fault flag doubles as the RUN/HALT state: once set, only reset
   // releases the registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc         <= PC_RESET;
         r_fault      <= 1'b0;
         r_fault_addr <= 32'h0;
         r_commit_cnt <= 32'h0;
      end else if (en && !r_fault) begin
         if (w_legal) begin
            r_pc         <= w_npc;
            r_commit_cnt <= r_commit_cnt + 32'd1;
         end else begin
            r_fault      <= 1'b1;
            r_fault_addr <= w_npc;
         end
      end
   end

   assign pc         = r_pc;
   assign pc_plus4   = w_pc_plus4;
   assign link_addr  = w_pc_plus4;
   assign npc        = w_npc;
   assign fault      = r_fault;
   assign fault_addr = r_fault_addr;
   assign commit_cnt = r_commit_cnt;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit
// Directed bench for fetch_pc_unit: sequential fetch, branches, jumps, jr,
// stall, fault capture/hold, reset out of HALT and range boundaries.
module tb_fetch_pc_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [1:0]  jump_op;
   logic        branch_taken;
   logic [15:0] imm16;
   logic [25:0] imm26;
   logic [31:0] rs_data;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] link_addr;
   logic [31:0] npc;
   logic        fault;
   logic [31:0] fault_addr;
   logic [31:0] commit_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fetch_pc_unit dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .jump_op      (jump_op),
      .branch_taken (branch_taken),
      .imm16        (imm16),
      .imm26        (imm26),
      .rs_data      (rs_data),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .link_addr    (link_addr),
      .npc          (npc),
      .fault        (fault),
      .fault_addr   (fault_addr),
      .commit_cnt   (commit_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic e_fault,
                            input logic [31:0] e_faddr, input logic [31:0] e_cnt);
      chk({tag, ".pc"}, pc, e_pc);
      chk({tag, ".fault"}, {31'h0, fault}, {31'h0, e_fault});
      chk({tag, ".fault_addr"}, fault_addr, e_faddr);
      chk({tag, ".cnt"}, commit_cnt, e_cnt);
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; jump_op = 2'b00; branch_taken = 1'b0;
      imm16 = 16'h0; imm26 = 26'h0; rs_data = 32'h0;
      step();
      reset = 1'b0;
      chk_state("reset", 32'h3000, 1'b0, 32'h0, 32'h0);

      // Sequential fetch
      en = 1'b1;
      step(); chk("seq1", pc, 32'h3004);
      step(); chk("seq2", pc, 32'h3008);
      step(); chk("seq3", pc, 32'h300C);
      chk("seq_cnt", commit_cnt, 32'd3);
      step(); chk("seq4", pc, 32'h3010);

      // Taken branch back by 16 bytes
      jump_op = 2'b01; imm16 = 16'hFFFC; branch_taken = 1'b1;
      #1 chk("br_t_npc", npc, 32'h3004);
      step(); chk("br_t_pc", pc, 32'h3004);

      jump_op = 2'b00;
      step(); step(); step();
      chk("to3010", pc, 32'h3010);
      jump_op = 2'b01; branch_taken = 1'b0;
      #1 chk("br_nt_npc", npc, 32'h3014);
      step(); chk("br_nt_pc", pc, 32'h3014);
      chk("br_cnt", commit_cnt, 32'd9);

      // j from 3020
      jump_op = 2'b00;
      step(); step(); step();
      chk("to3020", pc, 32'h3020);
      jump_op = 2'b10; imm26 = 26'h0000C10;
      #1 chk("j_link", link_addr, 32'h3024);
      chk("j_plus4", pc_plus4, 32'h3024);
      chk("j_npc", npc, 32'h3040);
      step(); chk("j_pc", pc, 32'h3040);

      // jr back to 3020, then jr to 3100
      jump_op = 2'b11; rs_data = 32'h3020;
      step(); chk("jr_back", pc, 32'h3020);
      rs_data = 32'h3100;
      step(); chk("jr_pc", pc, 32'h3100);
      chk("jr_cnt", commit_cnt, 32'd15);

      // branch_taken ignored outside JOP_BR
      jump_op = 2'b00; branch_taken = 1'bx;
      #1 chk("bt_x_npc", npc, 32'h3104);
      jump_op = 2'b10; imm26 = 26'h0000C40;
      #1 chk("bt_x_j", npc, 32'h3100);
      branch_taken = 1'b0;

      // Stall with an illegal target: nothing moves, no fault
      en = 1'b0; jump_op = 2'b11; rs_data = 32'h7000;
      #1 chk("stall_npc", npc, 32'h7000);
      for (int i = 0; i < 5; i++) step();
      chk_state("stall", 32'h3100, 1'b0, 32'h0, 32'd15);

      // Misaligned jr target
      en = 1'b1; rs_data = 32'h3002;
      step();
      chk_state("mis", 32'h3100, 1'b1, 32'h3002, 32'd15);
      rs_data = 32'h3200;
      step(); step();
      chk_state("halt", 32'h3100, 1'b1, 32'h3002, 32'd15);

      // Reset together with en out of HALT
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_state("rst_halt", 32'h3000, 1'b0, 32'h0, 32'h0);

      // Out-of-range jr target
      rs_data = 32'h7000;
      step();
      chk_state("oor", 32'h3000, 1'b1, 32'h7000, 32'h0);

      // Branch wrapping below IM_BASE
      reset = 1'b1; step(); reset = 1'b0;
      jump_op = 2'b01; branch_taken = 1'b1; imm16 = 16'h8000;
      #1 chk("wrap_npc", npc, 32'hFFFE_3004);
      step();
      chk_state("wrap", 32'h3000, 1'b1, 32'hFFFE_3004, 32'h0);

      // IM_LAST is legal, the word after it is not
      reset = 1'b1; step(); reset = 1'b0;
      jump_op = 2'b11; rs_data = 32'h6FFC;
      step();
      chk_state("last", 32'h6FFC, 1'b0, 32'h0, 32'd1);
      jump_op = 2'b00;
      step();
      chk_state("past", 32'h6FFC, 1'b1, 32'h7000, 32'd1);

      // Legal target just at IM_BASE via branch
      reset = 1'b1; step(); reset = 1'b0;
      jump_op = 2'b01; branch_taken = 1'b1; imm16 = 16'hFFFF;
      step();
      chk_state("base", 32'h3000, 1'b0, 32'h0, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter register and next-PC generator for the single-cycle MIPS datapath. It consumes the branch-taken decision from the comparator stage, jump controls, immediates and the `rs` operand, and registers the following PC on every enabled clock edge. It also provides the `jal` link address, detects illegal fetch targets, and counts committed PC updates for bench cross-checking.

## Interface
Parameters:
- `PC_RESET`, `32'h0000_3000`: PC value after reset.
- `IM_BASE`, `32'h0000_3000`: lowest legal fetch address.
- `IM_LAST`, `32'h0000_6FFC`: highest legal fetch address (inclusive).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `en` in 1: PC update enable; 0 = stall (hold everything).
- `jump_op` in 2: 00 sequential, 01 conditional branch, 10 `j`/`jal`, 11 `jr`.
- `branch_taken` in 1: comparator decision; used only when `jump_op`=01.
- `imm16` in 16: branch offset field.
- `imm26` in 26: jump index field.
- `rs_data` in 32: `jr` target.
- `pc` out 32: current fetch address (registered).
- `pc_plus4` out 32: `pc + 4` (combinational).
- `link_addr` out 32: `pc + 4`, written to `$31` by `jal`.
- `npc` out 32: combinational next-PC candidate.
- `fault` out 1: sticky illegal-target flag (registered).
- `fault_addr` out 32: offending target captured at fault (registered).
- `commit_cnt` out 32: number of committed PC updates (registered).

## Operation
- Next-PC selection (`npc`), all in 32-bit modulo arithmetic:
  - 00: `pc + 4`.
  - 01: if `branch_taken`, `pc + 4 + (sign_ext(imm16) << 2)`; otherwise `pc + 4`.
  - 10: `{pc_plus4[31:28], imm26, 2'b00}`.
  - 11: `rs_data`.
- Legality check: `npc` is legal iff `npc[1:0]==0` and `IM_BASE <= npc <= IM_LAST` (unsigned compare). Targets that wrap past `32'hFFFF_FFFC` or below 0 fall out of range and are illegal.
- State: RUN and HALT, encoded by `fault`.
  - RUN, `en`=1, legal `npc`: `pc <= npc`, `commit_cnt += 1`.
  - RUN, `en`=1, illegal `npc`: `pc` holds, `fault <= 1`, `fault_addr <= npc`, `commit_cnt` holds; go to HALT.
  - RUN, `en`=0: all registers hold; no legality check is performed.
  - HALT: all registers hold regardless of `en` or other inputs. Only `reset` exits HALT.
- `commit_cnt` wraps from `32'hFFFF_FFFF` to 0 without flagging.

## Timing
- Reset values: `pc`=`PC_RESET`, `fault`=0, `fault_addr`=0, `commit_cnt`=0.
- `reset` has priority over `en` and fault detection in the same cycle.
- Reset asserted mid-stall or in HALT takes effect at the next rising edge.
- Latency: `npc`, `pc_plus4` and `link_addr` follow inputs combinationally in the same cycle. `pc` shows the new value one edge later.
- `fault` and `fault_addr` become visible the edge after the illegal `npc` is sampled. `pc` at that point still holds the address of the faulting instruction.
- `branch_taken` is ignored when `jump_op`≠01. An X on `branch_taken` under those codes must not propagate to `npc`.

## Structure
- Shared package: `jump_op` encodings (`JOP_SEQ`, `JOP_BR`, `JOP_J`, `JOP_JR`), default `PC_RESET`, `IM_BASE` and `IM_LAST` constants.
- Sub-module `npc_calc`: purely combinational. Inputs are `pc`, `jump_op`, `branch_taken`, the immediates and `rs_data`. Outputs are `npc`, `pc_plus4` and `legal`.
- Top level holds only the PC, fault and counter registers.

## Test plan
- Reset then 3 cycles of `en`=1, `jump_op`=00 -> `pc` = 3000, 3004, 3008, 300C; `commit_cnt`=3.
- At `pc`=3010, `jump_op`=01, `imm16`=16'hFFFC:
  - `branch_taken`=1 -> next `pc`=3004.
  - `branch_taken`=0 -> next `pc`=3014.
- At `pc`=3020:
  - `jump_op`=10, `imm26`=26'h0000C10 -> `pc`=3040 and `link_addr`=3024 in the prior cycle.
  - `jump_op`=11, `rs_data`=32'h3100 -> `pc`=3100.
- `jump_op`=11 with `rs_data`=32'h3002, then separately with 32'h7000 -> `fault`=1, `fault_addr`=3002 (resp. 7000), `pc` holds. Further `en`=1 cycles leave `pc` and `commit_cnt` unchanged.
- `en`=0 for 5 cycles with `jump_op`=11 and an illegal `rs_data` -> no change and no fault. Then assert `reset` together with `en`=1 -> `pc`=3000, `fault`=0, `commit_cnt`=0.
- Branch from `pc`=3000 with `imm16`=16'h8000 (target wraps below `IM_BASE`) -> fault set, `fault_addr`=32'hFFFE_3004.
